// File: rtl/soc_it_slave_master.sv
// soc_it_slave_master
// Turns single application commands (with a separate write-beat stream) into
// burst transactions on the SoC-IT slave port. One command is in flight at a
// time. Read beats and a completion pulse are returned to the application.
// Every handshake wait is bounded by TIMEOUT cycles; an expired wait aborts
// the command and reports done_err.

module soc_it_slave_master #(
    parameter int MAX_LEN = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic         clk,
    input  logic         rst,

    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic         cmd_write,
    input  logic [63:0]  cmd_address,
    input  logic [3:0]   cmd_id,
    input  logic [3:0]   cmd_len,

    input  logic         wdata_valid,
    output logic         wdata_ready,
    input  logic [127:0] wdata,
    input  logic [15:0]  wdata_be,

    output logic         rdata_valid,
    output logic [127:0] rdata,
    output logic         rdata_last,
    output logic [3:0]   rdata_id,

    output logic         done,
    output logic [3:0]   done_id,
    output logic         done_err,

    output logic [63:0]  slave_address,
    output logic [3:0]   slave_transaction_id,
    output logic         slave_address_valid,
    input  logic         slave_address_ack,

    output logic [3:0]   slave_wrreq,
    input  logic         slave_wrack,
    output logic [15:0]  slave_be,
    output logic [127:0] slave_datain,

    output logic [3:0]   slave_rdreq,
    input  logic         slave_rdack,
    input  logic [127:0] slave_dataout
);

    localparam int WAIT_W = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WDATA,
        S_RDATA,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    // Command context latched at acceptance
    logic              wr_q;
    logic [63:0]       addr_q;
    logic [3:0]        id_q;
    logic [3:0]        len_q;

    // Progress tracking
    logic [3:0]        beat_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              abort_q;

    // Registered read-beat stream
    logic [127:0]      rdata_q;
    logic              rdata_valid_q;
    logic              rdata_last_q;
    logic [3:0]        rdata_id_q;

    // Per-cycle event strobes decoded by the FSM
    logic [3:0]        len_eff;
    logic              accept;
    logic              addr_hit;
    logic              wbeat;
    logic              rbeat;
    logic              timeout_hit;
    logic              waiting;
    logic              wait_expired;
    logic              last_beat;

    // Effective burst length: zero means one beat, oversize requests clamp
    always_comb begin
        if (cmd_len == 4'd0) begin
            len_eff = 4'd1;
        end else if (cmd_len > 4'(MAX_LEN)) begin
            len_eff = 4'(MAX_LEN);
        end else begin
            len_eff = cmd_len;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode, slave-port requests and application handshakes
    always_comb begin
        state_nxt           = state;
        cmd_ready           = 1'b0;
        wdata_ready         = 1'b0;
        slave_address_valid = 1'b0;
        slave_wrreq         = 4'd0;
        slave_rdreq         = 4'd0;
        slave_datain        = '0;
        slave_be            = '0;
        done                = 1'b0;
        done_id             = 4'd0;
        done_err            = 1'b0;
        accept              = 1'b0;
        addr_hit            = 1'b0;
        wbeat               = 1'b0;
        rbeat               = 1'b0;
        timeout_hit         = 1'b0;
        waiting             = 1'b0;
        wait_expired        = (wait_cnt == WAIT_W'(TIMEOUT - 1));
        last_beat           = (beat_cnt == 4'd1);

        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    accept    = 1'b1;
                    state_nxt = S_ADDR;
                end
            end

            S_ADDR: begin
                waiting             = 1'b1;
                slave_address_valid = 1'b1;
                if (slave_address_ack) begin
                    addr_hit  = 1'b1;
                    state_nxt = wr_q ? S_WDATA : S_RDATA;
                end else if (wait_expired) begin
                    timeout_hit = 1'b1;
                    state_nxt   = S_DONE;
                end
            end

            S_WDATA: begin
                waiting      = 1'b1;
                slave_datain = wdata;
                slave_be     = wdata_be;
                if (wdata_valid) begin
                    slave_wrreq = len_q;
                end
                // A wrack only counts when a beat is actually on offer
                wbeat       = slave_wrack & wdata_valid;
                wdata_ready = wbeat;
                if (wbeat) begin
                    if (last_beat) begin
                        state_nxt = S_DONE;
                    end
                end else if (wait_expired) begin
                    timeout_hit = 1'b1;
                    state_nxt   = S_DONE;
                end
            end

            S_RDATA: begin
                waiting     = 1'b1;
                slave_rdreq = len_q;
                rbeat       = slave_rdack;
                if (rbeat) begin
                    if (last_beat) begin
                        state_nxt = S_DONE;
                    end
                end else if (wait_expired) begin
                    timeout_hit = 1'b1;
                    state_nxt   = S_DONE;
                end
            end

            S_DONE: begin
                done      = 1'b1;
                done_id   = id_q;
                done_err  = abort_q;
                state_nxt = S_IDLE;
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Command context, beat/wait counters, abort flag and read-beat capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q          <= 1'b0;
            addr_q        <= '0;
            id_q          <= 4'd0;
            len_q         <= 4'd0;
            beat_cnt      <= 4'd0;
            wait_cnt      <= '0;
            abort_q       <= 1'b0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            rdata_last_q  <= 1'b0;
            rdata_id_q    <= 4'd0;
        end else begin
            rdata_valid_q <= 1'b0;
            rdata_last_q  <= 1'b0;

            if (accept) begin
                wr_q     <= cmd_write;
                addr_q   <= cmd_address;
                id_q     <= cmd_id;
                len_q    <= len_eff;
                abort_q  <= 1'b0;
                wait_cnt <= '0;
            end

            // Any accepted ack restarts the wait window
            if (addr_hit) begin
                beat_cnt <= len_q;
                wait_cnt <= '0;
            end else if (wbeat || rbeat) begin
                beat_cnt <= beat_cnt - 4'd1;
                wait_cnt <= '0;
            end else if (timeout_hit) begin
                abort_q <= 1'b1;
            end else if (waiting) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end

            if (rbeat) begin
                rdata_q       <= slave_dataout;
                rdata_valid_q <= 1'b1;
                rdata_last_q  <= last_beat;
                rdata_id_q    <= id_q;
            end
        end
    end

    assign slave_address        = addr_q;
    assign slave_transaction_id = id_q;
    assign rdata                = rdata_q;
    assign rdata_valid          = rdata_valid_q;
    assign rdata_last           = rdata_last_q;
    assign rdata_id             = rdata_id_q;

endmodule

// File: tb/tb_soc_it_slave_master.sv
// Testbench for soc_it_slave_master: a table of complete commands run against
// a reactive slave model, plus hand-written sequences for gapped reads,
// gapped writes, stray acks and reset in the middle of a burst.

module tb_soc_it_slave_master;

    logic         clk;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic         cmd_write;
    logic [63:0]  cmd_address;
    logic [3:0]   cmd_id;
    logic [3:0]   cmd_len;
    logic         wdata_valid;
    logic         wdata_ready;
    logic [127:0] wdata;
    logic [15:0]  wdata_be;
    logic         rdata_valid;
    logic [127:0] rdata;
    logic         rdata_last;
    logic [3:0]   rdata_id;
    logic         done;
    logic [3:0]   done_id;
    logic         done_err;
    logic [63:0]  slave_address;
    logic [3:0]   slave_transaction_id;
    logic         slave_address_valid;
    logic         slave_address_ack;
    logic [3:0]   slave_wrreq;
    logic         slave_wrack;
    logic [15:0]  slave_be;
    logic [127:0] slave_datain;
    logic [3:0]   slave_rdreq;
    logic         slave_rdack;
    logic [127:0] slave_dataout;

    soc_it_slave_master #(
        .MAX_LEN(8),
        .TIMEOUT(16)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .cmd_valid            (cmd_valid),
        .cmd_ready            (cmd_ready),
        .cmd_write            (cmd_write),
        .cmd_address          (cmd_address),
        .cmd_id               (cmd_id),
        .cmd_len              (cmd_len),
        .wdata_valid          (wdata_valid),
        .wdata_ready          (wdata_ready),
        .wdata                (wdata),
        .wdata_be             (wdata_be),
        .rdata_valid          (rdata_valid),
        .rdata                (rdata),
        .rdata_last           (rdata_last),
        .rdata_id             (rdata_id),
        .done                 (done),
        .done_id              (done_id),
        .done_err             (done_err),
        .slave_address        (slave_address),
        .slave_transaction_id (slave_transaction_id),
        .slave_address_valid  (slave_address_valid),
        .slave_address_ack    (slave_address_ack),
        .slave_wrreq          (slave_wrreq),
        .slave_wrack          (slave_wrack),
        .slave_be             (slave_be),
        .slave_datain         (slave_datain),
        .slave_rdreq          (slave_rdreq),
        .slave_rdack          (slave_rdack),
        .slave_dataout        (slave_dataout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Results of the last run_cmd
    int         r_beats, r_done, r_av, r_lat, r_last, r_req_bad, r_data_bad;
    int         r_addr_bad, r_busy_ready, r_acks, r_to;
    logic [3:0] r_req, r_done_id;
    logic       r_err, r_ready_after, r_last_with_done;

    // Issue one command and act as an always-ready slave (address ack optional)
    task automatic run_cmd(input logic w, input logic [63:0] a, input logic [3:0] id,
                           input logic [3:0] len, input bit ack_addr);
        int         n;
        bit         fin;
        logic [3:0] req;
        r_beats = 0; r_done = 0; r_av = 0; r_lat = 0; r_last = 0; r_req_bad = 0;
        r_data_bad = 0; r_addr_bad = 0; r_busy_ready = 0; r_acks = 0; r_to = 0;
        r_req = 4'd0; r_done_id = 4'd0; r_err = 1'b0; r_ready_after = 1'b0;
        r_last_with_done = 1'b0;

        cmd_valid = 1'b1; cmd_write = w; cmd_address = a; cmd_id = id; cmd_len = len;
        wdata_valid = w; wdata = 128'hA; wdata_be = 16'hFFFF;
        step();
        cmd_valid = 1'b0; cmd_len = 4'd0; cmd_address = '0; cmd_id = 4'd0;

        n = 0;
        fin = 1'b0;
        while (!fin && n < 100) begin
            n++;
            wdata = 128'hA + 128'(r_beats);
            if (cmd_ready) r_busy_ready++;
            if (slave_address_valid) begin
                r_av++;
                if (slave_address !== a || slave_transaction_id !== id) r_addr_bad++;
            end
            req = slave_wrreq | slave_rdreq;
            if (slave_wrreq != 4'd0 && slave_rdreq != 4'd0) r_req_bad++;
            if (req != 4'd0) begin
                if (r_req == 4'd0) r_req = req;
                else if (req != r_req) r_req_bad++;
            end
            slave_address_ack = slave_address_valid & ack_addr;
            slave_wrack       = (slave_wrreq != 4'd0);
            slave_rdack       = (slave_rdreq != 4'd0);
            slave_dataout     = 128'h100 + 128'(r_acks);
            if (rdata_valid) begin
                if (rdata !== 128'h100 + 128'(r_beats) || rdata_id !== id) r_data_bad++;
                if (rdata_last) r_last++;
                r_beats++;
            end
            if (done) begin
                r_done++;
                r_err = done_err;
                r_done_id = done_id;
                r_lat = n;
                r_last_with_done = rdata_valid & rdata_last;
                fin = 1'b1;
            end
            #1;
            if (wdata_ready) begin
                if (slave_datain !== wdata || slave_be !== wdata_be) r_data_bad++;
                r_beats++;
            end
            if (slave_rdack) r_acks++;
            step();
        end
        if (!fin) r_to = 1;
        slave_address_ack = 1'b0; slave_wrack = 1'b0; slave_rdack = 1'b0;
        wdata_valid = 1'b0;
        r_ready_after = cmd_ready;
        if (done) r_done++;
    endtask

    typedef struct {
        logic        w;
        logic [63:0] a;
        logic [3:0]  id;
        logic [3:0]  len;
        bit          ack;
        int          beats;
        logic [3:0]  req;
        logic        err;
        int          av;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int done_seen;

        vecs[0] = '{1'b1, 64'h1000,             4'd3,  4'd4,  1'b1, 4, 4'd4, 1'b0, 1,  6};
        vecs[1] = '{1'b0, 64'h2000,             4'd5,  4'd2,  1'b1, 2, 4'd2, 1'b0, 1,  4};
        vecs[2] = '{1'b1, 64'h3000,             4'd1,  4'd0,  1'b1, 1, 4'd1, 1'b0, 1,  3};
        vecs[3] = '{1'b0, 64'h4000,             4'd7,  4'd12, 1'b1, 8, 4'd8, 1'b0, 1, 10};
        vecs[4] = '{1'b1, 64'h5000,             4'd2,  4'd12, 1'b1, 8, 4'd8, 1'b0, 1, 10};
        vecs[5] = '{1'b0, 64'h6000,             4'd9,  4'd0,  1'b1, 1, 4'd1, 1'b0, 1,  3};
        vecs[6] = '{1'b0, 64'h7000,             4'd4,  4'd8,  1'b0, 0, 4'd0, 1'b1, 16, 17};
        vecs[7] = '{1'b1, 64'h8000,             4'hE,  4'd3,  1'b0, 0, 4'd0, 1'b1, 16, 17};
        vecs[8] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFF0, 4'hF, 4'd15, 1'b1, 8, 4'd8, 1'b0, 1, 10};
        vecs[9] = '{1'b1, 64'h10,               4'd8,  4'd8,  1'b1, 8, 4'd8, 1'b0, 1, 10};

        rst = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_address = '0; cmd_id = 4'd0; cmd_len = 4'd0;
        wdata_valid = 1'b0; wdata = '0; wdata_be = '0;
        slave_address_ack = 1'b0; slave_wrack = 1'b0; slave_rdack = 1'b0; slave_dataout = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset cmd_ready", 128'(cmd_ready), 128'd1);
        chk("reset addr_valid", 128'(slave_address_valid), 128'd0);
        chk("reset wrreq", 128'(slave_wrreq), 128'd0);
        chk("reset rdreq", 128'(slave_rdreq), 128'd0);
        chk("reset done", 128'(done), 128'd0);
        chk("reset rdata_valid", 128'(rdata_valid), 128'd0);
        chk("reset slave_address", 128'(slave_address), 128'd0);
        rst = 1'b1;
        step();

        // Table of complete commands
        for (int i = 0; i < 10; i++) begin
            run_cmd(vecs[i].w, vecs[i].a, vecs[i].id, vecs[i].len, vecs[i].ack);
            chk($sformatf("v%0d completed", i), 128'(r_to), 128'd0);
            chk($sformatf("v%0d beats", i), 128'(r_beats), 128'(vecs[i].beats));
            chk($sformatf("v%0d req", i), 128'(r_req), 128'(vecs[i].req));
            chk($sformatf("v%0d req stable", i), 128'(r_req_bad), 128'd0);
            chk($sformatf("v%0d done count", i), 128'(r_done), 128'd1);
            chk($sformatf("v%0d done_err", i), 128'(r_err), 128'(vecs[i].err));
            chk($sformatf("v%0d done_id", i), 128'(r_done_id), 128'(vecs[i].id));
            chk($sformatf("v%0d addr_valid cycles", i), 128'(r_av), 128'(vecs[i].av));
            chk($sformatf("v%0d addr/id driven", i), 128'(r_addr_bad), 128'd0);
            chk($sformatf("v%0d data", i), 128'(r_data_bad), 128'd0);
            chk($sformatf("v%0d done latency", i), 128'(r_lat), 128'(vecs[i].lat));
            chk($sformatf("v%0d rdata_last count", i), 128'(r_last),
                128'((!vecs[i].w && vecs[i].beats > 0) ? 1 : 0));
            chk($sformatf("v%0d last with done", i), 128'(r_last_with_done),
                128'((!vecs[i].w && vecs[i].beats > 0) ? 1 : 0));
            chk($sformatf("v%0d busy cmd_ready", i), 128'(r_busy_ready), 128'd0);
            chk($sformatf("v%0d ready after", i), 128'(r_ready_after), 128'd1);
        end

        // Stray acks while idle are ignored
        slave_address_ack = 1'b1; slave_wrack = 1'b1; slave_rdack = 1'b1; slave_dataout = 128'h55;
        step();
        slave_address_ack = 1'b0; slave_wrack = 1'b0; slave_rdack = 1'b0;
        chk("stray ack cmd_ready", 128'(cmd_ready), 128'd1);
        chk("stray ack rdata_valid", 128'(rdata_valid), 128'd0);
        chk("stray ack done", 128'(done), 128'd0);

        // Read, two beats acked in nonadjacent cycles
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_address = 64'h9000; cmd_id = 4'd5; cmd_len = 4'd2;
        step();
        cmd_valid = 1'b0;
        chk("nar addr_valid", 128'(slave_address_valid), 128'd1);
        slave_address_ack = 1'b1;
        step();
        slave_address_ack = 1'b0;
        chk("nar addr_valid low", 128'(slave_address_valid), 128'd0);
        chk("nar rdreq", 128'(slave_rdreq), 128'd2);
        step();
        chk("nar no beat yet", 128'(rdata_valid), 128'd0);
        slave_rdack = 1'b1; slave_dataout = 128'h11;
        step();
        slave_rdack = 1'b0; slave_dataout = 128'hDEAD;
        chk("nar beat0 valid", 128'(rdata_valid), 128'd1);
        chk("nar beat0 data", rdata, 128'h11);
        chk("nar beat0 last", 128'(rdata_last), 128'd0);
        chk("nar beat0 id", 128'(rdata_id), 128'd5);
        chk("nar beat0 no done", 128'(done), 128'd0);
        chk("nar rdreq held", 128'(slave_rdreq), 128'd2);
        step();
        chk("nar gap valid", 128'(rdata_valid), 128'd0);
        slave_rdack = 1'b1; slave_dataout = 128'h22;
        step();
        slave_rdack = 1'b0;
        chk("nar beat1 valid", 128'(rdata_valid), 128'd1);
        chk("nar beat1 data", rdata, 128'h22);
        chk("nar beat1 last", 128'(rdata_last), 128'd1);
        chk("nar done", 128'(done), 128'd1);
        chk("nar done_id", 128'(done_id), 128'd5);
        chk("nar done_err", 128'(done_err), 128'd0);
        step();
        chk("nar ready after", 128'(cmd_ready), 128'd1);
        chk("nar done one cycle", 128'(done), 128'd0);

        // Write with wdata_valid gapped for 3 cycles; wracks in the gap ignored
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_address = 64'hA000; cmd_id = 4'd6; cmd_len = 4'd4;
        wdata_valid = 1'b1; wdata = 128'hA; wdata_be = 16'h00FF;
        step();
        cmd_valid = 1'b0;
        slave_address_ack = 1'b1;
        step();
        slave_address_ack = 1'b0;
        slave_wrack = 1'b1;
        #1;
        chk("gap wrreq beat0", 128'(slave_wrreq), 128'd4);
        chk("gap ready beat0", 128'(wdata_ready), 128'd1);
        chk("gap be pass", 128'(slave_be), 128'h00FF);
        step();
        wdata_valid = 1'b0;
        for (int g = 0; g < 3; g++) begin
            #1;
            chk($sformatf("gap%0d wrreq", g), 128'(slave_wrreq), 128'd0);
            chk($sformatf("gap%0d ready", g), 128'(wdata_ready), 128'd0);
            chk($sformatf("gap%0d done", g), 128'(done), 128'd0);
            step();
        end
        wdata_valid = 1'b1;
        for (int b = 1; b < 4; b++) begin
            wdata = 128'hA + 128'(b);
            #1;
            chk($sformatf("gap beat%0d ready", b), 128'(wdata_ready), 128'd1);
            chk($sformatf("gap beat%0d datain", b), slave_datain, 128'hA + 128'(b));
            step();
        end
        slave_wrack = 1'b0; wdata_valid = 1'b0;
        chk("gap done", 128'(done), 128'd1);
        chk("gap done_id", 128'(done_id), 128'd6);
        chk("gap done_err", 128'(done_err), 128'd0);
        step();

        // Reset during a 4-beat read after the first beat
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_address = 64'hB000; cmd_id = 4'hC; cmd_len = 4'd4;
        step();
        cmd_valid = 1'b0;
        slave_address_ack = 1'b1;
        step();
        slave_address_ack = 1'b0;
        slave_rdack = 1'b1; slave_dataout = 128'h33;
        step();
        slave_rdack = 1'b0;
        chk("rst pre beat valid", 128'(rdata_valid), 128'd1);
        chk("rst pre rdreq", 128'(slave_rdreq), 128'd4);
        #2;
        rst = 1'b0;
        #1;
        chk("rst async rdreq", 128'(slave_rdreq), 128'd0);
        chk("rst async rdata_valid", 128'(rdata_valid), 128'd0);
        chk("rst async rdata", rdata, 128'd0);
        chk("rst async cmd_ready", 128'(cmd_ready), 128'd1);
        chk("rst async address", 128'(slave_address), 128'd0);
        chk("rst async done", 128'(done), 128'd0);
        done_seen = 0;
        repeat (2) begin
            step();
            if (done) done_seen++;
        end
        rst = 1'b1;
        step();
        if (done) done_seen++;
        step();
        if (done) done_seen++;
        chk("rst no done pulse", 128'(done_seen), 128'd0);
        run_cmd(1'b1, 64'hC000, 4'hD, 4'd1, 1'b1);
        chk("post-rst completed", 128'(r_to), 128'd0);
        chk("post-rst beats", 128'(r_beats), 128'd1);
        chk("post-rst done", 128'(r_done), 128'd1);
        chk("post-rst done_id", 128'(r_done_id), 128'hD);
        chk("post-rst done_err", 128'(r_err), 128'd0);
        chk("post-rst latency", 128'(r_lat), 128'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule

// File: doc/soc_it_slave_master.md
# soc_it_slave_master

Sequencing master that turns single command/data streams from the application into burst transactions on the SoC-IT slave port, and returns read data and completion status. It sits directly upstream of the SoC-IT slave port. It drives the address, transaction-id, request, byte-enable and write-data signals, and consumes address_ack, wrack, rdack and read data. One command is in flight at a time.

## Interface
- `MAX_LEN`, default 8: maximum burst length in 128-bit beats (1..15).
- `TIMEOUT`, default 1024: cycles allowed per handshake wait before abort (≥2).
- `clk` in 1: clock, all logic on rising edge.
- `rst` in 1: reset, asynchronous assert, active-low.
- `cmd_valid` in 1, `cmd_ready` out 1: command handshake.
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_address` in 64: start byte address.
- `cmd_id` in 4: transaction id.
- `cmd_len` in 4: beats.
  - 0 is treated as 1.
  - Values above MAX_LEN are clamped to MAX_LEN.
- `wdata_valid` in 1, `wdata_ready` out 1: write-beat handshake.
- `wdata` in 128, `wdata_be` in 16: write beat and byte enables.
- `rdata_valid` out 1, `rdata` out 128, `rdata_last` out 1, `rdata_id` out 4: read-beat stream. No backpressure.
- `done` out 1, `done_id` out 4, `done_err` out 1: one-cycle completion pulse.
- `slave_address` out 64, `slave_transaction_id` out 4, `slave_address_valid` out 1, `slave_address_ack` in 1: address phase.
- `slave_wrreq` out 4, `slave_wrack` in 1, `slave_be` out 16, `slave_datain` out 128: write data phase.
- `slave_rdreq` out 4, `slave_rdack` in 1, `slave_dataout` in 128: read data phase.

## Operation
States and transitions:
- IDLE
  - `cmd_ready`=1.
  - On `cmd_valid`: latch write, address, id and effective length L; then go to ADDR.
- ADDR
  - `slave_address_valid`=1. `slave_address` and `slave_transaction_id` are driven from the latched values and held stable.
  - On `slave_address_ack`: go to WDATA if write, else RDATA. Beat counter is set to L.
- WDATA
  - `slave_wrreq` = L while `wdata_valid`=1, else 0.
  - `slave_datain`/`slave_be` = `wdata`/`wdata_be` (combinational pass-through).
  - `wdata_ready` = `slave_wrack` & `wdata_valid`.
  - Each wrack consumes one beat and decrements the counter.
  - When the counter reaches 0, go to DONE.
- RDATA
  - `slave_rdreq` = L held constant.
  - Each `slave_rdack` registers `slave_dataout` into `rdata`, pulses `rdata_valid` the next cycle, and decrements the counter.
  - `rdata_last` is set on the final beat.
  - When the counter reaches 0, go to DONE.
- DONE
  - `done`=1, `done_id` = latched id, `done_err` = abort flag for one cycle.
  - Then go to IDLE.

Timeout:
- The wait counter resets on entry to ADDR, WDATA and RDATA, and on every ack.
- If it reaches TIMEOUT-1 without an ack: set the abort flag, drop all requests, and go to DONE.
- Remaining read beats are not emitted. Unconsumed write beats stay in the upstream stream (`wdata_ready` never asserted for them).

Other rules:
- Acks received outside their matching phase are ignored.
- `slave_wrack` with `wdata_valid`=0 is ignored.
- Address is not incremented by this block; the slave owns burst addressing.

## Timing
- Reset values: all outputs 0, except `cmd_ready`=1 (IDLE). State = IDLE, counters 0, abort flag 0.
- Reset mid-transaction: all requests are dropped in the same cycle (asynchronous). There is no completion pulse for the aborted command.
- Command accepted in cycle N: `slave_address_valid` rises in N+1.
- Ack seen in cycle M: `slave_address_valid` is 0 in M+1, and `slave_wrreq`/`slave_rdreq` may be nonzero from M+1.
- Read beat acked in cycle K: `rdata_valid` in K+1.
- Final beat in cycle K: DONE in K+1, `done` pulse in K+1.
  - For reads, the final `rdata_valid` and `done` coincide in K+1.
- Minimum single-beat read with immediate acks: accept N, address ack N+1, rdack N+2, `rdata_valid`+`done` N+3, `cmd_ready` N+4.
- Back-to-back write beats: acks on consecutive cycles give one beat per cycle.
- `cmd_ready` is 0 from N+1 until IDLE is re-entered.

## Test plan
- Write, `cmd_len`=4, address 0x1000, id 3, acks immediate:
  - 4 beats with data 0xA..0xD and be 0xFFFF are presented.
  - `slave_wrreq`=4 during the data phase; 4 `wdata_ready` pulses.
  - `done`=1, `done_id`=3, `done_err`=0.
- Read, `cmd_len`=2, id 5, rdack in two nonadjacent cycles with `slave_dataout` 0x11 then 0x22:
  - `rdata` is 0x11 then 0x22, each one cycle after its ack.
  - `rdata_last` is set on 0x22; `done` comes with the last beat.
- `cmd_len`=0 and `cmd_len`=12 (MAX_LEN=8):
  - Each command processes exactly 1 beat and 8 beats respectively.
- `slave_address_ack` never asserted, TIMEOUT=16:
  - `slave_address_valid` drops after 16 cycles.
  - `done_err`=1; no data requests are issued.
- Write with `wdata_valid` gapped for 3 cycles mid-burst:
  - `slave_wrreq`=0 during the gap.
  - A wrack during the gap is ignored; the beat count is unaffected.
- Reset asserted during RDATA after 1 of 4 beats:
  - All outputs go to reset values immediately.
  - No `done` pulse; the next command starts cleanly.
